// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Used by the RTL and available to any checker that needs the high-phase length.
package clk_div_pkg;

    typedef enum logic {StStop, StRun} state_e;

    localparam int unsigned MIN_DIV = 2;

    // Number of full source cycles pos_q stays high in one output period.
    function automatic int unsigned half_of(input int unsigned d, input logic odd);
        return odd ? (d - 1) / 2 : d / 2;
    endfunction

endpackage

// File: rtl/clk_div_negedge_retime.sv
// Negative-edge retime stage: stretches the high phase by half a cycle for odd ratios.
// Kept separate because it is the only negedge-clocked logic in the divider.
module clk_div_negedge_retime (
    input  logic clk,
    input  logic rst_n,
    input  logic pos_level,
    input  logic odd,
    output logic clk_out
);

    logic neg_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_level & odd;
        end
    end

    assign clk_out = pos_level | neg_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty integer clock divider with glitch-free divisor
// update and stop/start; divisor changes only take effect at a period boundary.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_valid,
    output logic         div_ready,
    output logic         div_err,
    output logic [W-1:0] div_active,
    output logic         tick,
    output logic         clk_out
);

    if (DEFAULT_DIV < MIN_DIV || (DEFAULT_DIV >> W) != 0) begin : g_bad_default_div
        $error("clk_div_prog: DEFAULT_DIV must lie in 2..2^W-1");
    end

    localparam logic [W-1:0] DefDiv  = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MinDivW = W'(MIN_DIV);
    localparam logic [W-1:0] One     = W'(1);

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pend_vld_q, pend_vld_d;
    logic         pos_q, pos_d;
    logic         tick_q, tick_d;
    logic         err_q, err_d;

    logic [W-1:0] half;
    logic [W-1:0] cnt_inc;
    logic         wrap;
    logic         boundary;
    logic         accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StStop;
            cnt_q      <= '0;
            div_q      <= DefDiv;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            pos_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        accept   = div_valid & ~pend_vld_q;
        half     = W'(half_of(32'(div_q), div_q[0]));
        cnt_inc  = cnt_q + One;
        wrap     = (cnt_q == div_q - One);
        boundary = (state_q == StStop) | wrap;

        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        pos_d      = pos_q;
        tick_d     = 1'b0;
        err_d      = accept & (div_in < MinDivW);

        // A pending divisor blocks acceptance, so apply and store never collide.
        if (boundary && pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
        end else if (accept && (div_in >= MinDivW)) begin
            pend_d     = div_in;
            pend_vld_d = 1'b1;
        end

        if (boundary) begin
            cnt_d = '0;
            if (en) begin
                state_d = StRun;
                pos_d   = 1'b1;
                tick_d  = 1'b1;
            end else begin
                state_d = StStop;
                pos_d   = 1'b0;
            end
        end else begin
            cnt_d = cnt_inc;
            pos_d = (cnt_inc < half);
        end
    end

    always_comb begin
        div_ready  = ~pend_vld_q;
        div_active = div_q;
        tick       = tick_q;
        div_err    = err_q;
    end

    clk_div_negedge_retime u_retime (
        .clk       (clk),
        .rst_n     (rst_n),
        .pos_level (pos_q),
        .odd       (div_q[0]),
        .clk_out   (clk_out)
    );

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider. It is the successor to the fixed odd-ratio divider.
- Divides the source clock by any D in 2..2^W-1, odd or even.
- Output duty cycle is exactly 50%; odd ratios use a half-cycle negedge retime.
- New divisors are loaded through a valid/ready handshake and applied only at a period boundary, so clk_out never glitches.
- Includes a glitch-free stop/start enable. Feeds clock-domain generation for peripheral blocks.

Parameters:
- W, 8, divisor width in bits.
- DEFAULT_DIV, 5, divisor in force after reset. Must be in 2..2^W-1 (elaboration-time check).

Ports:
- clk  input  1  source clock; counter logic on posedge, retime flop on negedge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run request; sampled only at period boundaries or while stopped.
- div_in  input  W  requested divisor.
- div_valid  input  1  div_in is valid this cycle.
- div_ready  output  1  no update pending; a new divisor can be accepted.
- div_err  output  1  one-cycle pulse: an accepted divisor < 2 was discarded.
- div_active  output  W  divisor currently in force.
- tick  output  1  one-cycle pulse, in clk domain, in the first cycle of each output period.
- clk_out  output  1  divided clock.

Behaviour:
- Reset (async, all flops including the negedge flop):
  - state=STOP, cnt=0, pos_q=0, neg_q=0, clk_out=0, tick=0, div_err=0.
  - div_ready=1, div_active=DEFAULT_DIV, no pending update.
- Derived values:
  - odd = div_active[0].
  - H = D/2 when D is even; H = (D-1)/2 when D is odd.
- STOP state:
  - cnt=0, pos_q=0, clk_out=0.
  - A pending divisor is applied immediately at the next posedge.
  - At a posedge with en=1: state←RUN, cnt←0, pos_q←1, tick←1.
- RUN state, every posedge:
  - cnt_next = (cnt==D-1) ? 0 : cnt+1.
  - pos_q ← (cnt_next < H) when running.
  - tick ← (cnt_next==0).
- Wrap (the posedge where cnt==D-1):
  - Boundary actions: apply the pending divisor to div_active, then sample en.
  - If en=0: state←STOP, pos_q←0, tick←0.
- Negedge retime: neg_q ← pos_q & odd.
- Output: clk_out = pos_q | neg_q.
  - Even D: high exactly D/2 source cycles.
  - Odd D: high (D-1)/2 + 0.5 cycles, i.e. D/2.
  - Rising edge of clk_out always aligns to a clk posedge; period is exactly D.
- Glitch freedom: pos_q and neg_q are both low in the last source cycle of every period (for all D ≥ 2), so changing odd/D at the wrap cannot glitch.
- Handshake:
  - Transfer occurs when div_valid & div_ready at a posedge.
  - div_in ≥ 2: stored as pending; div_ready←0 until the pending value is applied at a boundary, then div_ready←1 on that same edge.
  - div_in < 2: discarded; div_err pulses 1 cycle; div_ready stays 1; div_active unchanged.
  - Transfer on the wrap edge itself: the value goes to pending and takes effect at the following wrap.
  - In STOP, a divisor accepted at edge k is active at edge k+1.
- Simultaneous events at a wrap: apply the pending divisor first, then the en decision. The new period (or the restart) uses the new D.
- Reset mid-period: clk_out drops to 0 asynchronously and any pending update is lost.
- D=2: even branch, H=1, clk_out = clk/2.

Decomposition:
- Package clk_div_pkg:
  - state enum {STOP, RUN}.
  - Constant MIN_DIV=2.
  - Function half_of(D, odd) returning H, shared by RTL and bench checker.
- One natural sub-module: clk_div_negedge_retime.
  - Holds the single negedge flop with async reset, plus the OR output.
  - Isolates the only negedge logic, for constraint/STA purposes.

Test Plan:
- Reset release, en=1, DEFAULT_DIV=5 → first clk_out rise at 1st posedge after rst_n. Period 5 clk cycles, high 2.5 cycles. tick every 5 cycles; div_active=5.
- Write D=4 at cnt=2 → div_ready low. The current period still lasts 5 cycles, then period 4 with high 2.0 cycles. div_ready returns 1 on the switch edge; no pulse narrower than 2 cycles.
- Write D=1, then D=0 → div_err pulses once per write. div_ready stays 1; div_active unchanged; waveform unchanged.
- D=3 → high 1.5 cycles, period 3. D=2 → high 1, period 2. D=2^W-1=255 → high 127.5 cycles.
- Drop en mid-period with D=6 → the period completes (3 high/3 low), then clk_out stays 0. Raise en → clk_out rises at the next posedge with cnt=0.
- Assert rst_n=0 while clk_out=1 with a write pending → clk_out=0 immediately. After release: div_active=5 and the pending write is discarded.
